// File: rtl/stage_mem_if.sv
// Data-bus bundle between the memory stage (master) and the memory system (slave).
// Latency: none, wiring only.
// Backpressure: slave holds off the master by withholding bus_ack.
//
// Signals:
//   bus_addr   word address, low 2 bits always 0
//   bus_wdata  store data (lane-replicated for byte stores)
//   bus_be     byte enables, bit i = byte lane i
//   bus_we     1 store, 0 load
//   bus_req    request, held until ack or timeout
//   bus_ack    one-cycle acknowledge, bus_rdata valid in the same cycle
//   bus_rdata  read data
interface stage_mem_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_we;
  logic        bus_req;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_be, bus_we, bus_req,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_be, bus_we, bus_req,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: EX->MEM inputs in, MEM->WB register out; loads/stores over req/ack bus.
// Latency: non-memory ops 1 cycle; memory ops >= 3 cycles (IDLE -> WAIT -> DONE), bounded by BUS_TIMEOUT.
// Backpressure: mem_busy (combinational) freezes IF/ID/EX while an access is outstanding.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_stall                  global pipeline stall (honoured only in IDLE)
//   i_mem_opt                0 NONE, 1 LW, 2 LB, 3 LBU, 4 SW, 5 SB, 6/7 NONE
//   i_mem_addr, i_mem_data   byte address and store data from EX
//   i_alu_result             pass-through value for non-memory ops
//   i_wb_reg_addr_in         destination register, 0 = none
//   bus                      stage_mem_if master modport (data bus)
//   o_mem_busy               hold upstream stages
//   o_wb_data, o_wb_reg_addr write-back value/register (register 0 = no write)
//   o_bus_err                one-cycle pulse when an access times out
//   o_align_err              one-cycle pulse on trapped misaligned LW/SW
// Optional feature macro: MEM_UNALIGNED_TRAP_EN (trap misaligned LW/SW instead of aligning down).
module stage_mem #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic [2:0]  i_mem_opt,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic [31:0] i_alu_result,
  input  logic [4:0]  i_wb_reg_addr_in,
  stage_mem_if.master bus,
  output logic        o_mem_busy,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_reg_addr,
  output logic        o_bus_err,
  output logic        o_align_err
);

  localparam int              CW       = $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BUS_TIMEOUT - 1);

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t        r_state,       w_state_nxt;
  logic [CW-1:0] r_cnt,         w_cnt_nxt;
  logic [31:0]   r_bus_addr,    w_bus_addr_nxt;
  logic [31:0]   r_bus_wdata,   w_bus_wdata_nxt;
  logic [3:0]    r_bus_be,      w_bus_be_nxt;
  logic          r_bus_we,      w_bus_we_nxt;
  logic          r_bus_req,     w_bus_req_nxt;
  logic [31:0]   r_wb_data,     w_wb_data_nxt;
  logic [4:0]    r_wb_reg_addr, w_wb_reg_addr_nxt;
  logic          r_bus_err,     w_bus_err_nxt;
  logic          r_align_err,   w_align_err_nxt;
  // Access context kept for the WAIT state: load flavour, byte lane, destination.
  logic [2:0]    r_ld_op,       w_ld_op_nxt;
  logic [1:0]    r_lane,        w_lane_nxt;
  logic [4:0]    r_dest,        w_dest_nxt;

  logic        w_is_word, w_is_byte, w_is_mem, w_is_store, w_trap;
  logic [3:0]  w_be_issue;
  logic [31:0] w_wdata_issue;
  logic [7:0]  w_rd_byte;
  logic [31:0] w_load_val;

  // Opcodes 6/7 fall out of every decode term and so behave as NONE.
  assign w_is_word  = (i_mem_opt == OP_LW) || (i_mem_opt == OP_SW);
  assign w_is_byte  = (i_mem_opt == OP_LB) || (i_mem_opt == OP_LBU) || (i_mem_opt == OP_SB);
  assign w_is_mem   = w_is_word || w_is_byte;
  assign w_is_store = (i_mem_opt == OP_SW) || (i_mem_opt == OP_SB);

`ifdef MEM_UNALIGNED_TRAP_EN
  assign w_trap = w_is_word && (i_mem_addr[1:0] != 2'b00);
`else
  // Misaligned word accesses silently align down; align_err never fires.
  assign w_trap = 1'b0;
`endif

  assign w_be_issue    = w_is_word ? 4'b1111 : (4'b0001 << i_mem_addr[1:0]);
  assign w_wdata_issue = (i_mem_opt == OP_SB) ? {4{i_mem_data[7:0]}} : i_mem_data;

  assign w_rd_byte  = bus.bus_rdata[{r_lane, 3'b000} +: 8];
  assign w_load_val = (r_ld_op == OP_LB)  ? {{24{w_rd_byte[7]}}, w_rd_byte} :
                      (r_ld_op == OP_LBU) ? {24'h000000, w_rd_byte} :
                                            bus.bus_rdata;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_bus_addr_nxt    = r_bus_addr;
    w_bus_wdata_nxt   = r_bus_wdata;
    w_bus_be_nxt      = r_bus_be;
    w_bus_we_nxt      = r_bus_we;
    w_bus_req_nxt     = r_bus_req;
    w_wb_data_nxt     = r_wb_data;
    w_wb_reg_addr_nxt = r_wb_reg_addr;
    w_bus_err_nxt     = r_bus_err;
    w_align_err_nxt   = r_align_err;
    w_ld_op_nxt       = r_ld_op;
    w_lane_nxt        = r_lane;
    w_dest_nxt        = r_dest;
    o_mem_busy        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!i_stall) begin
          if (!w_is_mem) begin
            w_wb_data_nxt     = i_alu_result;
            w_wb_reg_addr_nxt = i_wb_reg_addr_in;
          end else begin
            o_mem_busy        = 1'b1;
            w_wb_reg_addr_nxt = 5'd0;
            if (w_trap) begin
              w_align_err_nxt = 1'b1;
              w_state_nxt     = S_DONE;
            end else begin
              w_bus_addr_nxt  = {i_mem_addr[31:2], 2'b00};
              w_bus_we_nxt    = w_is_store;
              w_bus_be_nxt    = w_be_issue;
              w_bus_wdata_nxt = w_wdata_issue;
              w_bus_req_nxt   = 1'b1;
              w_cnt_nxt       = '0;
              w_ld_op_nxt     = i_mem_opt;
              w_lane_nxt      = i_mem_addr[1:0];
              w_dest_nxt      = i_wb_reg_addr_in;
              w_state_nxt     = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        o_mem_busy = 1'b1;
        // Ack is checked first so an ack on the last allowed cycle still completes cleanly.
        if (bus.bus_ack) begin
          w_bus_req_nxt = 1'b0;
          w_state_nxt   = S_DONE;
          if (r_bus_we) begin
            w_wb_reg_addr_nxt = 5'd0;
          end else begin
            w_wb_data_nxt     = w_load_val;
            w_wb_reg_addr_nxt = r_dest;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_bus_req_nxt     = 1'b0;
          w_bus_err_nxt     = 1'b1;
          w_wb_reg_addr_nxt = 5'd0;
          w_state_nxt       = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DONE: begin
        // Result is visible this cycle only; clear it so WB never writes twice.
        w_wb_reg_addr_nxt = 5'd0;
        w_bus_err_nxt     = 1'b0;
        w_align_err_nxt   = 1'b0;
        w_state_nxt       = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bus_addr    <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_bus_be      <= 4'd0;
      r_bus_we      <= 1'b0;
      r_bus_req     <= 1'b0;
      r_wb_data     <= 32'd0;
      r_wb_reg_addr <= 5'd0;
      r_bus_err     <= 1'b0;
      r_align_err   <= 1'b0;
      r_ld_op       <= 3'd0;
      r_lane        <= 2'd0;
      r_dest        <= 5'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bus_addr    <= w_bus_addr_nxt;
      r_bus_wdata   <= w_bus_wdata_nxt;
      r_bus_be      <= w_bus_be_nxt;
      r_bus_we      <= w_bus_we_nxt;
      r_bus_req     <= w_bus_req_nxt;
      r_wb_data     <= w_wb_data_nxt;
      r_wb_reg_addr <= w_wb_reg_addr_nxt;
      r_bus_err     <= w_bus_err_nxt;
      r_align_err   <= w_align_err_nxt;
      r_ld_op       <= w_ld_op_nxt;
      r_lane        <= w_lane_nxt;
      r_dest        <= w_dest_nxt;
    end
  end

  assign bus.bus_addr   = r_bus_addr;
  assign bus.bus_wdata  = r_bus_wdata;
  assign bus.bus_be     = r_bus_be;
  assign bus.bus_we     = r_bus_we;
  assign bus.bus_req    = r_bus_req;
  assign o_wb_data      = r_wb_data;
  assign o_wb_reg_addr  = r_wb_reg_addr;
  assign o_bus_err      = r_bus_err;
  assign o_align_err    = r_align_err;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: random + directed instruction stream, scoreboard queues for bus requests and
// write-back events, reference results computed from the instruction semantics.
module tb_stage_mem;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  mem_opt;
  logic [31:0] mem_addr, mem_data, alu_result;
  logic [4:0]  wb_reg_addr_in;
  logic        mem_busy;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg_addr;
  logic        bus_err, align_err;

  stage_mem_if bus_if ();

  stage_mem #(.BUS_TIMEOUT(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_stall          (stall),
    .i_mem_opt        (mem_opt),
    .i_mem_addr       (mem_addr),
    .i_mem_data       (mem_data),
    .i_alu_result     (alu_result),
    .i_wb_reg_addr_in (wb_reg_addr_in),
    .bus              (bus_if),
    .o_mem_busy       (mem_busy),
    .o_wb_data        (wb_data),
    .o_wb_reg_addr    (wb_reg_addr),
    .o_bus_err        (bus_err),
    .o_align_err      (align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;   // expected cycles of bus_req; <= 0 means do not check
  } bus_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        berr;
    logic        aerr;
  } wb_exp_t;

  bus_exp_t bq[$];
  wb_exp_t  wq[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] last_pass_rd = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics of a load, from the instruction definitions.
  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] rdata, input logic [1:0] lane);
    logic [31:0] b;
    b = (rdata >> (8 * lane)) & 32'hFF;
    if (op == 3'd1) return rdata;
    if (op == 3'd3) return b;
    return (b >= 32'd128) ? b - 32'd256 : b;
  endfunction

  task automatic garbage();
    stall          = 1'($urandom);
    mem_opt        = 3'($urandom);
    mem_addr       = $urandom;
    mem_data       = $urandom;
    alu_result     = $urandom;
    wb_reg_addr_in = 5'($urandom);
  endtask

  // Issue one instruction in IDLE and follow it to completion. Enter/leave just after a rising edge.
  // d = WAIT cycle index in which ack is given; d >= T means never (timeout).
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] rdata, input int d);
    bit is_mem, is_word, is_load, trap;
    bus_exp_t be_e;
    wb_exp_t  wb_e;
    is_mem  = (op >= 3'd1) && (op <= 3'd5);
    is_word = (op == 3'd1) || (op == 3'd4);
    is_load = (op >= 3'd1) && (op <= 3'd3);
    trap    = 1'b0;
`ifdef MEM_UNALIGNED_TRAP_EN
    trap = is_word && (addr[1:0] != 2'b00);
`endif
    stall = 1'b0; mem_opt = op; mem_addr = addr; mem_data = data;
    alu_result = alu; wb_reg_addr_in = rd;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;

    if (!is_mem) begin
      if (rd != 5'd0) begin wb_e = '{rd, alu, 1'b0, 1'b0}; wq.push_back(wb_e); end
      last_pass_rd = rd;
    end else begin
      last_pass_rd = 5'd0;
      if (trap) begin
        wb_e = '{5'd0, 32'd0, 1'b0, 1'b1}; wq.push_back(wb_e);
      end else begin
        be_e.addr  = addr & 32'hFFFF_FFFC;
        be_e.be    = is_word ? 4'b1111 : 4'(1 << addr[1:0]);
        be_e.we    = !is_load;
        be_e.wdata = (op == 3'd5) ? data[7:0] * 32'h0101_0101 : data;
        be_e.len   = (d < T) ? d + 1 : T;
        bq.push_back(be_e);
        if (d >= T) begin
          wb_e = '{5'd0, 32'd0, 1'b1, 1'b0}; wq.push_back(wb_e);
        end else if (is_load && rd != 5'd0) begin
          wb_e = '{rd, load_val(op, rdata, addr[1:0]), 1'b0, 1'b0}; wq.push_back(wb_e);
        end
      end
    end

    @(negedge clk);
    chk("busy_issue", 32'(mem_busy), 32'(is_mem));
    @(posedge clk); #1;
    if (is_mem) begin
      if (!trap) begin
        for (int k = 0; k < T; k++) begin
          garbage();
          bus_if.bus_ack   = (k == d);
          bus_if.bus_rdata = (k == d) ? rdata : $urandom;
          @(negedge clk);
          chk("busy_wait", 32'(mem_busy), 32'd1);
          @(posedge clk); #1;
          if (k == d) break;
        end
      end
      garbage();
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
      chk("busy_done", 32'(mem_busy), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic stall_burst(input int n);
    // A held pass-through result would look like a second write; retire it first.
    if (last_pass_rd != 5'd0) do_op(3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 0);
    for (int k = 0; k < n; k++) begin
      garbage();
      stall = 1'b1;
      @(negedge clk);
      chk("busy_stall", 32'(mem_busy), 32'd0);
      chk("req_stall", 32'(bus_if.bus_req), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops expected bus requests and write-back events as the DUT presents them.
  bit       in_req = 1'b0;
  bit       have_cur = 1'b0;
  int       req_cnt = 0;
  bus_exp_t cur;
  wb_exp_t  wexp;

  always @(negedge clk) begin
    if (!rst) begin
      in_req   = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (bus_if.bus_req) begin
        if (!in_req) begin
          in_req  = 1'b1;
          req_cnt = 0;
          if (bq.size() == 0) begin
            chk("bus_unexpected_req", 32'd1, 32'd0);
            have_cur = 1'b0;
          end else begin
            cur = bq.pop_front();
            have_cur = 1'b1;
            chk("bus_addr", bus_if.bus_addr, cur.addr);
            chk("bus_be", 32'(bus_if.bus_be), 32'(cur.be));
            chk("bus_we", 32'(bus_if.bus_we), 32'(cur.we));
            if (cur.we) chk("bus_wdata", bus_if.bus_wdata, cur.wdata);
          end
        end
        req_cnt++;
      end else if (in_req) begin
        in_req = 1'b0;
        if (have_cur && cur.len > 0) chk("req_len", 32'(req_cnt), 32'(cur.len));
      end

      if (wb_reg_addr != 5'd0 || bus_err || align_err) begin
        if (wq.size() == 0) begin
          chk("wb_unexpected_event", {wb_reg_addr, 2'b00, bus_err, align_err}, 32'd0);
        end else begin
          wexp = wq.pop_front();
          chk("wb_reg_addr", 32'(wb_reg_addr), 32'(wexp.rd));
          if (wexp.rd != 5'd0) chk("wb_data", wb_data, wexp.data);
          chk("bus_err", 32'(bus_err), 32'(wexp.berr));
          chk("align_err", 32'(align_err), 32'(wexp.aerr));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; mem_opt = 3'd0; mem_addr = 32'd0; mem_data = 32'd0;
    alu_result = 32'd0; wb_reg_addr_in = 5'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
    chk("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_reg_addr", 32'(wb_reg_addr), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Pass-through.
    do_op(3'd0, 32'd0, 32'd0, 32'h1234_5678, 5'd3, 32'd0, 0);
    chk("pass_req_low", 32'(bus_if.bus_req), 32'd0);
    // Byte loads from 0x1002, lane 2 = 0x80, ack two cycles after request.
    do_op(3'd2, 32'h0000_1002, 32'd0, 32'd0, 5'd5, 32'h0080_0000, 2);
    do_op(3'd3, 32'h0000_1002, 32'd0, 32'd0, 5'd6, 32'h0080_0000, 2);
    // Byte store to lane 3.
    do_op(3'd5, 32'h0000_2003, 32'h0000_00AB, 32'd0, 5'd9, 32'd0, 1);
    // Timeout, then ack on the very last allowed WAIT cycle.
    do_op(3'd1, 32'h0000_0100, 32'd0, 32'd0, 5'd4, 32'd0, 99);
    do_op(3'd1, 32'h0000_0104, 32'd0, 32'd0, 5'd8, 32'hCAFE_F00D, T - 1);
    // Misaligned word store, and a misaligned word load.
    do_op(3'd4, 32'h0000_3001, 32'h5555_AAAA, 32'd0, 5'd0, 32'd0, 0);
    do_op(3'd1, 32'h0000_3003, 32'd0, 32'd0, 5'd10, 32'h0BAD_BEEF, 0);
    // Unused opcodes behave as NONE.
    do_op(3'd7, 32'h0000_0008, 32'd0, 32'h0000_0077, 5'd11, 32'd0, 0);

    // Asynchronous reset in the middle of WAIT.
    stall = 1'b0; mem_opt = 3'd1; mem_addr = 32'h0000_0040; wb_reg_addr_in = 5'd7;
    bq.push_back('{32'h0000_0040, 4'b1111, 1'b0, 32'd0, 0});
    last_pass_rd = 5'd0;
    @(posedge clk); #1;
    mem_opt = 3'd0; wb_reg_addr_in = 5'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("async_rst_wb_reg", 32'(wb_reg_addr), 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    do_op(3'd1, 32'h0000_0080, 32'd0, 32'd0, 5'd12, 32'h1357_9BDF, 0);

    // Random stream.
    for (int i = 0; i < 250; i++) begin
      int d;
      if ($urandom_range(0, 5) == 0) stall_burst($urandom_range(1, 3));
      d = ($urandom_range(0, 24) == 0) ? 99 : $urandom_range(0, 4);
      do_op(3'($urandom), $urandom, $urandom, $urandom, 5'($urandom), $urandom, d);
    end

    do_op(3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bus_queue_drained", 32'(bq.size()), 32'd0);
    chk("wb_queue_drained", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
